pe_ctx_sequencer: RTL

Controller for the PE array's two-phase context interface. Clears every PE, streams configuration words from a valid/ready source into the PEs' context buffers one at a time, then drives the shared run strobe for exactly the loaded number of contexts. It finishes with a drain window so the PE input and result registers settle before `done`. It sits between the array-level configuration DMA/host port and the `init`/`run`/`PE_inst`/`rst` pins of every PE.

---
 rtl/pe_ctx_sequencer_pkg.sv | 26 ++
 rtl/pe_load_addr_gen.sv | 57 +++++
 rtl/pe_ctx_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pe_ctx_sequencer_pkg.sv
// Shared types and defaults for the PE context sequencer.
// INST_W default follows the global PE_INST_WIDTH define when one is provided.
`ifndef PE_INST_WIDTH
`define PE_INST_WIDTH 48
`endif

package pe_ctx_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  localparam int unsigned INST_W_DEF    = `PE_INST_WIDTH;
  localparam int unsigned CTX_DEPTH_DEF = 4;
  localparam int unsigned SEQ_CTX_W     = $clog2(CTX_DEPTH_DEF + 1);

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pe_load_addr_gen.sv
// PE-major load address generator: ctx index wraps at the loaded context count and
// carries into the PE index; last flags the final word of the load.
module pe_load_addr_gen
  import pe_ctx_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned CTX_DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clr_i,
  input  logic                                 adv_i,
  input  logic [$clog2(CTX_DEPTH+1)-1:0]       ctx_num_i,
  output logic [clog2_min1(NUM_PE)-1:0]        pe_idx_o,
  output logic                                 last_o
);

  localparam int unsigned CW = $clog2(CTX_DEPTH + 1);
  localparam int unsigned PW = clog2_min1(NUM_PE);
  localparam logic [PW-1:0] PE_LAST = PW'(NUM_PE - 1);

  logic [CW-1:0] ctx_q, ctx_d;
  logic [PW-1:0] pe_q, pe_d;
  logic          ctx_wrap;

  assign ctx_wrap = (ctx_q == ctx_num_i - CW'(1));

  always_comb begin
    ctx_d = ctx_q;
    pe_d  = pe_q;
    if (clr_i) begin
      ctx_d = '0;
      pe_d  = '0;
    end else if (adv_i) begin
      if (ctx_wrap) begin
        ctx_d = '0;
        pe_d  = (pe_q == PE_LAST) ? '0 : pe_q + PW'(1);
      end else begin
        ctx_d = ctx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_q <= '0;
      pe_q  <= '0;
    end else begin
      ctx_q <= ctx_d;
      pe_q  <= pe_d;
    end
  end

  assign pe_idx_o = pe_q;
  assign last_o   = ctx_wrap && (pe_q == PE_LAST);

endmodule

// File: rtl/pe_ctx_sequencer.sv
// PE array context sequencer: clear, load contexts PE-major, run n strobes, drain, done.
// Optional SEQ_PERF_CNT_EN adds saturating perf_stall / perf_total counters.
module pe_ctx_sequencer
  import pe_ctx_sequencer_pkg::*;
#(
  parameter int unsigned INST_W    = INST_W_DEF,
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned CTX_DEPTH = 4,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(CTX_DEPTH+1)-1:0] ctx_num,
  input  logic                           cfg_valid,
  input  logic [INST_W-1:0]              cfg_data,
  output logic                           cfg_ready,
  output logic                           pe_clr,
  output logic [NUM_PE-1:0]              pe_init,
  output logic [INST_W-1:0]              pe_inst,
  output logic                           pe_run,
  output logic                           busy,
  output logic                           done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                    perf_stall,
  output logic [15:0]                    perf_total
`endif
);

  localparam int unsigned CW = $clog2(CTX_DEPTH + 1);
  localparam int unsigned PW = clog2_min1(NUM_PE);
  localparam int unsigned DW = clog2_min1(DRAIN_CYC);
  localparam logic [CW-1:0] CTX_MAX    = CW'(CTX_DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     ctx_n_q, ctx_n_d;
  logic [CW-1:0]     run_cnt_q, run_cnt_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              busy_q, cfg_ready_q, pe_clr_q, pe_run_q, done_q;
  logic [NUM_PE-1:0] pe_init_q, init_oh;
  logic [INST_W-1:0] pe_inst_q;
  logic [PW-1:0]     pe_idx;
  logic              load_last, hs, start_ok;

  assign start_ok = (state_q == S_IDLE) && start && !abort && (ctx_num != '0);
  assign hs       = cfg_ready_q && cfg_valid && !abort;

  pe_load_addr_gen #(
    .NUM_PE    (NUM_PE),
    .CTX_DEPTH (CTX_DEPTH)
  ) u_addr (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (state_q == S_CLEAR),
    .adv_i     (hs),
    .ctx_num_i (ctx_n_q),
    .pe_idx_o  (pe_idx),
    .last_o    (load_last)
  );

  always_comb begin
    init_oh         = '0;
    init_oh[pe_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ctx_n_d     = ctx_n_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_CLEAR;
          ctx_n_d = (ctx_num > CTX_MAX) ? CTX_MAX : ctx_num;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (hs && load_last) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (run_cnt_q == ctx_n_q - CW'(1)) begin
          state_d     = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
        else                           drain_cnt_d = drain_cnt_q + DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Strobes are registered from the next state so each output is a flop, not a decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ctx_n_q     <= '0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      pe_clr_q    <= 1'b0;
      pe_run_q    <= 1'b0;
      done_q      <= 1'b0;
      pe_init_q   <= '0;
      pe_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctx_n_q     <= ctx_n_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= (state_d != S_IDLE);
      cfg_ready_q <= (state_d == S_LOAD);
      pe_clr_q    <= (state_d == S_CLEAR);
      pe_run_q    <= (state_d == S_RUN);
      done_q      <= (state_d == S_DONE);
      pe_init_q   <= hs ? init_oh : '0;
      if (hs) pe_inst_q <= cfg_data;
    end
  end

  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;
  assign pe_clr    = pe_clr_q;
  assign pe_run    = pe_run_q;
  assign done      = done_q;
  assign pe_init   = pe_init_q;
  assign pe_inst   = pe_inst_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] stall_q, total_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      total_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
      total_q <= '0;
    end else if (state_q != S_IDLE) begin
      if (total_q != '1) total_q <= total_q + 16'd1;
      if (state_q == S_LOAD && !cfg_valid && stall_q != '1) stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_total = total_q;
`endif

endmodule
